// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory load/store unit.
// Holds the access-size encodings, the LSU state enum and the helper that
// turns an access size plus byte offset into a 4-bit byte-lane write mask.
package dmem_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } lsu_state_e;

  // Byte lanes touched by an access. Half accesses pick the upper or lower
  // pair from offset[1]; illegal sizes touch nothing.
  function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                           input logic [1:0] offset);
    logic [3:0] mask;
    mask = 4'b0000;
    case (size)
      SZ_B:    mask = 4'b0001 << offset;
      SZ_H:    mask = offset[1] ? 4'b1100 : 4'b0011;
      SZ_W:    mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// Word-organised storage for the LSU: DEPTH x 32 bits with per-byte write
// enables. Writes happen on the rising edge; a read is registered on the same
// edge when rd_en is set and the output then holds until the next read.
// Contents are never reset.
//   clk    : clock
//   wr_be  : byte-lane write enables (bit i writes wdata[8i+7:8i])
//   rd_en  : capture mem[idx] into rdata on this edge
//   idx    : word index
//   wdata  : write data, already placed in its byte lanes
//   rdata  : registered read word
module dmem_bank
  import dmem_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic [3:0]    wr_be,
  input  logic          rd_en,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];
  logic [31:0] rdata_q;
  logic [31:0] rdata_d;

  // Read data only moves on a read, so it stays valid while a response waits.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) rdata_d = mem[idx];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_be[i]) mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/dmem_lsu.sv
// Load/store unit in front of a single-port data memory.
// One request at a time: accepted in IDLE, optionally delayed WAIT_CYCLES in
// WAIT, then presented in RESP until the consumer takes it. Stores and the
// load read both happen on the acceptance edge; error requests never touch
// memory and answer rdata=0, err=1.
//   clk, rst                        : clock, synchronous active-high reset
//   req_valid/req_ready             : request handshake
//   req_write, req_addr, req_size,
//   req_unsigned, req_wdata         : request fields
//   rsp_valid/rsp_ready             : response handshake
//   rsp_rdata, rsp_err              : response payload
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         AW        = $clog2(DEPTH);
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  lsu_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [1:0]  size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic [1:0]  off_q, off_d;
  logic        err_q, err_d;

  logic        accept;
  logic        req_err;
  logic        misaligned;
  logic        out_of_range;
  logic [3:0]  wr_be;
  logic        rd_en;
  logic [31:0] wdata_lanes;
  logic [31:0] bank_rdata;
  logic [31:0] shifted;
  logic [31:0] load_data;

  assign req_ready = (state_q == IDLE);
  assign accept    = req_valid && req_ready;

  // Any address bit at or above the bank size is out of range: no wrap.
  always_comb begin
    misaligned = 1'b0;
    case (req_size)
      SZ_B:    misaligned = 1'b0;
      SZ_H:    misaligned = req_addr[0];
      SZ_W:    misaligned = |req_addr[1:0];
      default: misaligned = 1'b1;
    endcase
    out_of_range = (req_addr >> (AW + 2)) != 32'd0;
    req_err      = misaligned || out_of_range;
  end

  // Store data arrives right-aligned; replicate it so every lane the mask
  // may select carries the right bytes.
  always_comb begin
    case (req_size)
      SZ_B:    wdata_lanes = {4{req_wdata[7:0]}};
      SZ_H:    wdata_lanes = {2{req_wdata[15:0]}};
      default: wdata_lanes = req_wdata;
    endcase
    wr_be = (accept && req_write && !req_err) ? lane_mask(req_size, req_addr[1:0]) : 4'b0000;
    rd_en = accept && !req_write && !req_err;
  end

  dmem_bank #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_bank (
    .clk   (clk),
    .wr_be (wr_be),
    .rd_en (rd_en),
    .idx   (req_addr[AW+1:2]),
    .wdata (wdata_lanes),
    .rdata (bank_rdata)
  );

  // Next state and request-field capture. The counter runs down in WAIT and
  // hands over to RESP when it hits 1.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    write_d    = write_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    off_d      = off_q;
    err_d      = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          write_d    = req_write;
          size_d     = req_size;
          unsigned_d = req_unsigned;
          off_d      = req_addr[1:0];
          err_d      = req_err;
          if (WAIT_CYCLES > 0) begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      write_q    <= 1'b0;
      size_q     <= 2'b00;
      unsigned_q <= 1'b0;
      off_q      <= 2'b00;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      write_q    <= write_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      off_q      <= off_d;
      err_q      <= err_d;
    end
  end

  // Load extraction from the word captured at acceptance. Output is zero
  // outside RESP and for stores or errors.
  always_comb begin
    shifted   = bank_rdata >> {off_q, 3'b000};
    load_data = 32'd0;
    if (state_q == RESP && !err_q && !write_q) begin
      case (size_q)
        SZ_B:    load_data = {{24{~unsigned_q & shifted[7]}}, shifted[7:0]};
        SZ_H:    load_data = {{16{~unsigned_q & shifted[15]}}, shifted[15:0]};
        SZ_W:    load_data = bank_rdata;
        default: load_data = 32'd0;
      endcase
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = load_data;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu. The main instance uses WAIT_CYCLES=1; two
// extra instances (WAIT_CYCLES=0 and 3) share the same inputs and are only
// examined after a common reset to compare response latency.
module tb_dmem_lsu;
  import dmem_pkg::*;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] expRdata;
    logic        expErr;
  } vector_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        rsp_ready;

  logic        req_ready_1, rsp_valid_1, rsp_err_1;
  logic [31:0] rsp_rdata_1;
  logic        req_ready_0, rsp_valid_0, rsp_err_0;
  logic [31:0] rsp_rdata_0;
  logic        req_ready_3, rsp_valid_3, rsp_err_3;
  logic [31:0] rsp_rdata_3;

  int numVectors    = 0;
  int numMiscompares = 0;

  vector_t vecs[$];

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  dmem_lsu #(.DEPTH(1024), .WAIT_CYCLES(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready_1), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid_1), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata_1), .rsp_err(rsp_err_1)
  );

  dmem_lsu #(.DEPTH(1024), .WAIT_CYCLES(0)) dut_w0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready_0), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid_0), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata_0), .rsp_err(rsp_err_0)
  );

  dmem_lsu #(.DEPTH(1024), .WAIT_CYCLES(3)) dut_w3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready_3), .req_write(req_write),
    .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid_3), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata_3), .rsp_err(rsp_err_3)
  );

  // Hard stop in case something hangs despite the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    numVectors++;
    if (actual !== expected) begin
      numMiscompares++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic addVec(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                        input logic uns, input logic [31:0] wdata,
                        input logic [31:0] expRdata, input logic expErr);
    vector_t v;
    v.wr = wr; v.addr = addr; v.size = size; v.uns = uns; v.wdata = wdata;
    v.expRdata = expRdata; v.expErr = expErr;
    vecs.push_back(v);
  endtask

  // One full transaction on the main instance with rsp_ready held high.
  // latency counts cycles after the acceptance edge until rsp_valid.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [1:0] size,
                               input logic uns, input logic [31:0] wdata,
                               output logic [31:0] rdata, output logic err,
                               output int latency);
    int guard;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_size = size;
    req_unsigned = uns; req_wdata = wdata; rsp_ready = 1'b1;
    guard = 0;
    while (!req_ready_1 && guard < 20) begin
      tick();
      guard++;
    end
    tick();
    req_valid = 1'b0;
    latency = 1;
    while (!rsp_valid_1 && latency < 20) begin
      tick();
      latency++;
    end
    rdata = rsp_rdata_1;
    err   = rsp_err_1;
    tick();
  endtask

  initial begin
    logic [31:0] rdata;
    logic        err;
    int          latency;
    int          guard;
    int          first0, first1, first3;

    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0;
    req_size = SZ_W; req_unsigned = 1'b0; req_wdata = 32'd0; rsp_ready = 1'b1;

    // Reset state
    tick();
    tick();
    checkOutput("reset rsp_valid", {31'd0, rsp_valid_1}, 32'd0);
    checkOutput("reset rsp_rdata", rsp_rdata_1, 32'd0);
    checkOutput("reset rsp_err", {31'd0, rsp_err_1}, 32'd0);
    rst = 1'b0;
    checkOutput("reset req_ready", {31'd0, req_ready_1}, 32'd1);

    // Directed vector table
    addVec(1, 32'h10,   SZ_W,  0, 32'hDEADBEEF, 32'h0,        0);
    addVec(0, 32'h10,   SZ_W,  0, 32'h0,        32'hDEADBEEF, 0);
    addVec(1, 32'h11,   SZ_B,  0, 32'h00000080, 32'h0,        0);
    addVec(0, 32'h11,   SZ_B,  0, 32'h0,        32'hFFFFFF80, 0);
    addVec(0, 32'h11,   SZ_B,  1, 32'h0,        32'h00000080, 0);
    addVec(0, 32'h10,   SZ_W,  0, 32'h0,        32'hDEAD80EF, 0);
    addVec(0, 32'h13,   SZ_H,  0, 32'h0,        32'h0,        1);
    addVec(1, 32'h12,   SZ_W,  0, 32'h12345678, 32'h0,        1);
    addVec(0, 32'h10,   SZ_W,  0, 32'h0,        32'hDEAD80EF, 0);
    addVec(0, 32'h1000, SZ_W,  0, 32'h0,        32'h0,        1);
    addVec(0, 32'h10,   2'b11, 0, 32'h0,        32'h0,        1);
    addVec(1, 32'h14,   SZ_W,  0, 32'h11223344, 32'h0,        0);
    addVec(1, 32'h16,   SZ_H,  0, 32'hABCDCAFE, 32'h0,        0);
    addVec(0, 32'h16,   SZ_H,  1, 32'h0,        32'h0000CAFE, 0);
    addVec(0, 32'h16,   SZ_H,  0, 32'h0,        32'hFFFFCAFE, 0);
    addVec(0, 32'h14,   SZ_W,  0, 32'h0,        32'hCAFE3344, 0);
    addVec(0, 32'h17,   SZ_B,  1, 32'h0,        32'h000000CA, 0);
    addVec(0, 32'h14,   SZ_B,  0, 32'h0,        32'h00000044, 0);
    addVec(0, 32'h10,   SZ_W,  1, 32'h0,        32'hDEAD80EF, 0);
    addVec(1, 32'hFFC,  SZ_W,  0, 32'hA5A5A5A5, 32'h0,        0);
    addVec(0, 32'hFFE,  SZ_H,  0, 32'h0,        32'hFFFFA5A5, 0);
    addVec(1, 32'h1010, SZ_W,  0, 32'h0,        32'h0,        1);
    addVec(0, 32'h10,   SZ_W,  0, 32'h0,        32'hDEAD80EF, 0);
    addVec(1, 32'h12,   SZ_B,  0, 32'h1234565A, 32'h0,        0);
    addVec(0, 32'h12,   SZ_H,  0, 32'h0,        32'hFFFFDE5A, 0);
    addVec(0, 32'h10,   SZ_H,  1, 32'h0,        32'h000080EF, 0);
    addVec(0, 32'h13,   SZ_B,  0, 32'h0,        32'hFFFFFFDE, 0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].uns, vecs[i].wdata,
                    rdata, err, latency);
      checkOutput($sformatf("vec%0d rdata", i), rdata, vecs[i].expRdata);
      checkOutput($sformatf("vec%0d err", i), {31'd0, err}, {31'd0, vecs[i].expErr});
      checkOutput($sformatf("vec%0d latency", i), 32'(latency), 32'd2);
    end

    // Back-pressure: response held for 5 cycles while a competing store is
    // offered and must be ignored.
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_size = SZ_W;
    req_unsigned = 1'b0; rsp_ready = 1'b0;
    tick();
    req_write = 1'b1; req_wdata = 32'h00000000;
    guard = 0;
    while (!rsp_valid_1 && guard < 20) begin
      tick();
      guard++;
    end
    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("stall%0d rsp_valid", c), {31'd0, rsp_valid_1}, 32'd1);
      checkOutput($sformatf("stall%0d rsp_rdata", c), rsp_rdata_1, 32'hDE5A80EF);
      checkOutput($sformatf("stall%0d req_ready", c), {31'd0, req_ready_1}, 32'd0);
      tick();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    checkOutput("release rsp_valid", {31'd0, rsp_valid_1}, 32'd0);
    checkOutput("release req_ready", {31'd0, req_ready_1}, 32'd1);
    applyStimulus(0, 32'h10, SZ_W, 0, 32'h0, rdata, err, latency);
    checkOutput("after stall word", rdata, 32'hDE5A80EF);

    // Reset during WAIT: the store stays committed, the response is dropped.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_size = SZ_H;
    req_unsigned = 1'b0; req_wdata = 32'h00001234; rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    rst = 1'b1;
    tick();
    checkOutput("midreset rsp_valid", {31'd0, rsp_valid_1}, 32'd0);
    checkOutput("midreset rsp_err", {31'd0, rsp_err_1}, 32'd0);
    rst = 1'b0;
    checkOutput("midreset req_ready", {31'd0, req_ready_1}, 32'd1);
    applyStimulus(0, 32'h20, SZ_H, 1, 32'h0, rdata, err, latency);
    checkOutput("midreset LHU", rdata, 32'h00001234);

    // Latency across WAIT_CYCLES settings, all instances starting together.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("lat w0 req_ready", {31'd0, req_ready_0}, 32'd1);
    checkOutput("lat w3 req_ready", {31'd0, req_ready_3}, 32'd1);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40; req_size = SZ_W;
    req_unsigned = 1'b0; req_wdata = 32'h87654321; rsp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (6) tick();
    req_valid = 1'b1; req_write = 1'b0; rsp_ready = 1'b0;
    tick();
    req_valid = 1'b0;
    first0 = 0; first1 = 0; first3 = 0;
    for (int c = 1; c <= 6; c++) begin
      if (rsp_valid_0 && first0 == 0) first0 = c;
      if (rsp_valid_1 && first1 == 0) first1 = c;
      if (rsp_valid_3 && first3 == 0) first3 = c;
      if (c < 6) tick();
    end
    checkOutput("lat w0 cycle", 32'(first0), 32'd1);
    checkOutput("lat w1 cycle", 32'(first1), 32'd2);
    checkOutput("lat w3 cycle", 32'(first3), 32'd4);
    checkOutput("lat w0 rdata", rsp_rdata_0, 32'h87654321);
    checkOutput("lat w1 rdata", rsp_rdata_1, 32'h87654321);
    checkOutput("lat w3 rdata", rsp_rdata_3, 32'h87654321);
    checkOutput("lat w0 err", {31'd0, rsp_err_0}, 32'd0);
    checkOutput("lat w3 err", {31'd0, rsp_err_3}, 32'd0);
    rsp_ready = 1'b1;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
    $finish;
  end

endmodule

// File: doc/dmem_lsu.md
DMEM_LSU -- requirements
Module: dmem_lsu

Interface
REQ-001 SHALL have parameter DEPTH, default 1024: number of 32-bit words; a power of 2, at least 4.
REQ-002 SHALL have parameter WAIT_CYCLES, default 1: extra response delay in cycles; range 0..15.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all logic is on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset that is synchronous and active-high.
REQ-005 SHALL have port req_valid, input, 1 bit: request present.
REQ-006 SHALL have port req_ready, output, 1 bit: the block can accept a request.
REQ-007 SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-008 SHALL have port req_addr, input, 32 bits: byte address.
REQ-009 SHALL have port req_size, input, 2 bits: 00 = byte, 01 = half, 10 = word, 11 = illegal.
REQ-010 SHALL have port req_unsigned, input, 1 bit: zero-extend load data (LBU/LHU).
REQ-011 SHALL have port req_wdata, input, 32 bits: store data, right-aligned.
REQ-012 SHALL have port rsp_valid, output, 1 bit: response present.
REQ-013 SHALL have port rsp_ready, input, 1 bit: consumer accepts the response.
REQ-014 SHALL have port rsp_rdata, output, 32 bits: extended load data; 0 for stores and errors.
REQ-015 SHALL have port rsp_err, output, 1 bit: misaligned, out-of-range or illegal-size access.

Function
REQ-016 SHALL implement an FSM with states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 SHALL accept a request on an edge where req_valid and req_ready are both 1, and SHALL latch all request fields on that edge.
REQ-018 SHALL, on acceptance, go to WAIT when WAIT_CYCLES > 0 (counter loaded with WAIT_CYCLES), otherwise go directly to RESP.
REQ-019 SHALL decrement the counter each cycle in WAIT and go to RESP when it reaches 1.
REQ-020 SHALL assert rsp_valid first on cycle WAIT_CYCLES+1 after acceptance.
REQ-021 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready=1; on that edge it SHALL return to IDLE, with no back-to-back bypass.
REQ-022 SHALL flag an error when: size is half and addr[0]=1; size is word and addr[1:0]!=0; size is 11; or addr >= 4*DEPTH.
REQ-023 SHALL NOT modify memory for an error request, and SHALL return rsp_rdata = 0 with rsp_err = 1.
REQ-024 SHALL commit a non-error store on the acceptance edge, writing only the addressed byte lanes: byte -> lane addr[1:0]; half -> lanes addr[1]*2 and +1; word -> all four lanes.
REQ-025 SHALL capture a load's word on the acceptance edge and then extract the addressed byte or half, sign-extending unless req_unsigned=1.
REQ-026 SHALL ignore req_unsigned for word loads.
REQ-027 SHALL use word index addr[log2(DEPTH)+1:2]; higher address bits SHALL only participate in the range check, and there SHALL be no wrap-around.
REQ-028 SHALL ignore req_valid while not in IDLE.

Reset
REQ-029 SHALL, while rst=1 at an edge, set the state to IDLE, the counter to 0, rsp_valid=0, rsp_rdata=0 and rsp_err=0.
REQ-030 SHALL, with rst deasserted, present req_ready=1 in the first cycle.
REQ-031 SHALL NOT reset memory contents.
REQ-032 SHALL, on reset mid-operation, drop the pending response; a store already accepted SHALL remain committed.

Structure
REQ-033 SHALL place the size encodings (SZ_B, SZ_H, SZ_W), the state enum and the lane-mask function in package dmem_pkg.
REQ-034 SHALL put the storage in one sub-module, dmem_bank: DEPTH x 32 bits, 4-bit byte-write-enable, synchronous write, read registered on the same edge.

Verification
REQ-035 SHALL verify: WAIT_CYCLES=1, SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> rsp_valid on cycle 2 after acceptance, rdata 0xDEADBEEF, err 0.
REQ-036 SHALL verify: after REQ-035, SB addr 0x11 data 0x80, then LB 0x11 -> 0xFFFFFF80; LBU 0x11 -> 0x00000080; LW 0x10 -> 0xDEAD80EF.
REQ-037 SHALL verify: LH 0x13 -> err 1, rdata 0; SW 0x12 -> err 1 and word 0x10 unchanged; LW 0x1000 with DEPTH=1024 -> err 1.
REQ-038 SHALL verify: hold rsp_ready=0 for 5 cycles -> rsp_valid and data stable and req_ready=0 throughout; release -> IDLE on the next cycle.
REQ-039 SHALL verify: WAIT_CYCLES=0 -> rsp_valid on the cycle after acceptance; WAIT_CYCLES=3 -> on cycle 4.
REQ-040 SHALL verify: rst=1 during WAIT after an SH 0x20 of 0x1234 -> rsp_valid=0 next cycle, req_ready=1 after release; LHU 0x20 -> 0x00001234.
